// File: rtl/sp_ram_arb_init_pkg.sv
// Shared types and constants for the single-port RAM arbiter with init sweep.
package sp_ram_arb_init_pkg;

  typedef enum logic {INIT, RUN} state_e;

  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned MACRO_W = 16;

endpackage

// File: rtl/sp_ram_arb_init_rr_arb2.sv
// Two-way round-robin arbiter; the pointer flips only when both requesters contend.
module sp_ram_arb_init_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic ptr_q;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = ptr_q ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else if (en && (req == 2'b11)) begin
      ptr_q <= ~ptr_q;
    end
  end

endmodule

// File: rtl/sp_ram_arb_init.sv
// Shares one single-port SRAM between two requesters and clears every entry after
// reset or on flush.
module sp_ram_arb_init
  import sp_ram_arb_init_pkg::*;
#(
  parameter int unsigned       DATA_W     = 64,
  parameter int unsigned       ADDR_W     = 8,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
  input  logic                      Clk_CI,
  input  logic                      Rst_RI,
  input  logic                      Flush_SI,
  output logic                      Busy_SO,
  input  logic [NUM_REQ-1:0]        Req_SI,
  output logic [NUM_REQ-1:0]        Gnt_SO,
  input  logic [NUM_REQ-1:0]        WrEn_SI,
  input  logic [NUM_REQ*ADDR_W-1:0] Addr_DI,
  input  logic [NUM_REQ*DATA_W-1:0] WrData_DI,
  input  logic [NUM_REQ*DATA_W/8-1:0] BEn_SI,
  output logic [NUM_REQ-1:0]        RValid_SO,
  output logic [DATA_W-1:0]         RData_DO,
  output logic                      CSel_SO,
  output logic                      WrEn_SO,
  output logic [DATA_W/8-1:0]       BEn_SO,
  output logic [ADDR_W-1:0]         Addr_DO,
  output logic [DATA_W-1:0]         WrData_DO,
  input  logic [DATA_W-1:0]         RdData_DI
);

  localparam int unsigned BeW = DATA_W / 8;

  if ((DATA_W % MACRO_W) != 0) begin : gen_bad_width
    $error("DATA_W must be a multiple of the macro slice width");
  end

  state_e               state_q;
  logic [ADDR_W-1:0]    cnt_q;
  logic                 busy_q;
  logic [NUM_REQ-1:0]   rvalid_q;
  logic [NUM_REQ-1:0]   gnt;
  logic                 arb_en;

  // A flush in RUN blocks that cycle's grants so nothing races the sweep.
  assign arb_en = (state_q == RUN) && !Flush_SI;

  sp_ram_arb_init_rr_arb2 u_arb (
    .clk (Clk_CI),
    .rst (Rst_RI),
    .en  (arb_en),
    .req (Req_SI),
    .gnt (gnt)
  );

  assign Gnt_SO    = gnt;
  assign Busy_SO   = busy_q;
  assign RValid_SO = rvalid_q;
  assign RData_DO  = RdData_DI;

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      state_q  <= INIT;
      cnt_q    <= '0;
      busy_q   <= 1'b1;
      rvalid_q <= '0;
    end else begin
      rvalid_q <= gnt & Req_SI & ~WrEn_SI;
      case (state_q)
        INIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == {ADDR_W{1'b1}}) begin
            state_q <= RUN;
            busy_q  <= 1'b0;
          end
        end
        RUN: begin
          if (Flush_SI) begin
            state_q <= INIT;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= INIT;
          cnt_q   <= '0;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    CSel_SO   = 1'b0;
    WrEn_SO   = 1'b0;
    BEn_SO    = '0;
    Addr_DO   = cnt_q;
    WrData_DO = INIT_VALUE;
    if (state_q == INIT) begin
      CSel_SO = 1'b1;
      WrEn_SO = 1'b1;
      BEn_SO  = '1;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (gnt[i]) begin
          CSel_SO   = 1'b1;
          WrEn_SO   = WrEn_SI[i];
          BEn_SO    = BEn_SI[i*BeW +: BeW];
          Addr_DO   = Addr_DI[i*ADDR_W +: ADDR_W];
          WrData_DO = WrData_DI[i*DATA_W +: DATA_W];
        end
      end
    end
  end

endmodule
